// File: rtl/debounce_defs_pkg.sv
// rtl/debounce_defs_pkg.sv - shared state encoding for the per-channel debounce FSM
package debounce_defs;

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'd0,
    HIGH_CHECK  = 2'd1,
    HIGH_STABLE = 2'd2,
    LOW_CHECK   = 2'd3
  } db_state_e;

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - one switch channel: 2-flop synchronizer, counter debounce FSM, edge strobes
module debounce_bit
  import debounce_defs::*;
#(
  parameter int unsigned STABLE_CYCLES = 500000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic raw_in,
  output logic db_out,
  output logic rise_out,
  output logic fall_out
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1_q, s2_q;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= LOW_STABLE;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= raw_in;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // The counter is only advanced inside a CHECK state and the FSM leaves
  // that state on CNT_LAST, so it can never wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      LOW_STABLE: begin
        db_d = 1'b0;
        if (s2_q) begin
          state_d = HIGH_CHECK;
          cnt_d   = CNT_ONE;
        end
      end
      HIGH_CHECK: begin
        if (!s2_q) begin
          state_d = LOW_STABLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH_STABLE;
          db_d    = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HIGH_STABLE: begin
        db_d = 1'b1;
        if (!s2_q) begin
          state_d = LOW_CHECK;
          cnt_d   = CNT_ONE;
        end
      end
      LOW_CHECK: begin
        if (s2_q) begin
          state_d = HIGH_STABLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LOW_STABLE;
          db_d    = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = LOW_STABLE;
    endcase
  end

  assign db_out   = db_q;
  assign rise_out = rise_q;
  assign fall_out = fall_q;

endmodule

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - WIDTH independent switch debouncers with rise/fall strobes
module switch_debouncer
  import debounce_defs::*;
#(
  parameter int unsigned WIDTH         = 2,
  parameter int unsigned STABLE_CYCLES = 500000
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] rise_out,
  output logic [WIDTH-1:0] fall_out
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_bit #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_bit (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .raw_in  (raw_in[i]),
      .db_out  (db_out[i]),
      .rise_out(rise_out[i]),
      .fall_out(fall_out[i])
    );
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// tb/tb_switch_debouncer.sv - scoreboard bench for switch_debouncer (STABLE_CYCLES=4, WIDTH=2)
module tb_switch_debouncer;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [1:0] raw_in;
  logic [1:0] db_out, rise_out, fall_out;

  switch_debouncer #(.WIDTH(2), .STABLE_CYCLES(4)) dut (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .raw_in  (raw_in),
    .db_out  (db_out),
    .rise_out(rise_out),
    .fall_out(fall_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [1:0] db;
    logic [1:0] rise;
    logic [1:0] fall;
    bit         ha;
    logic       sum;
    logic       carry;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_vec  = 0;
  int   n_fail = 0;
  bit   got;

  task automatic push(input int c, input logic [1:0] db, input logic [1:0] rise,
                      input logic [1:0] fall);
    exp_t x;
    x.cyc = c; x.db = db; x.rise = rise; x.fall = fall;
    x.ha = 1'b0; x.sum = 1'b0; x.carry = 1'b0;
    exp_q.push_back(x);
  endtask

  task automatic push_ha(input int c, input logic [1:0] db, input logic sum, input logic carry);
    exp_t x;
    x.cyc = c; x.db = db; x.rise = 2'b00; x.fall = 2'b00;
    x.ha = 1'b1; x.sum = sum; x.carry = carry;
    exp_q.push_back(x);
  endtask

  // A level step driven after edge c0 is first sampled at c0+1 and lands on db_out at c0+6.
  task automatic expect_step(input int c0, input logic [1:0] db_old, input logic [1:0] db_new,
                             input logic [1:0] rise, input logic [1:0] fall);
    push(c0 + 5, db_old, 2'b00, 2'b00);
    push(c0 + 6, db_new, rise, fall);
    push(c0 + 7, db_new, 2'b00, 2'b00);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  always @(negedge clk_in) begin
    got = 1'b0;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      n_vec++;
      n_fail++;
      $display("FAIL missed_check cyc=%0d: expectation for cyc %0d never compared", cyc, e.cyc);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      got = 1'b1;
      n_vec++;
      if ({db_out, rise_out, fall_out} !== {e.db, e.rise, e.fall}) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d: db/rise/fall got %b/%b/%b want %b/%b/%b",
                 cyc, db_out, rise_out, fall_out, e.db, e.rise, e.fall);
      end
      if (e.ha) begin
        n_vec++;
        if ({db_out[0] & db_out[1], db_out[0] ^ db_out[1]} !== {e.carry, e.sum}) begin
          n_fail++;
          $display("FAIL half_adder cyc=%0d: carry/sum got %b/%b want %b/%b", cyc,
                   db_out[0] & db_out[1], db_out[0] ^ db_out[1], e.carry, e.sum);
        end
      end
    end
    if (!got) begin
      n_vec++;
      if ((rise_out | fall_out) !== 2'b00) begin
        n_fail++;
        $display("FAIL spurious_pulse cyc=%0d: rise/fall got %b/%b want 00/00",
                 cyc, rise_out, fall_out);
      end
    end
  end

  logic [1:0] sw_raw  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [1:0] sw_prev [4] = '{2'b01, 2'b00, 2'b01, 2'b10};
  logic [1:0] sw_rise [4] = '{2'b00, 2'b01, 2'b10, 2'b01};
  logic [1:0] sw_fall [4] = '{2'b01, 2'b00, 2'b01, 2'b00};
  logic       sw_sum  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic       sw_carry[4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  int c0;

  initial begin
    // 1: reset held three edges with both switches already high
    rst_in = 1'b1;
    raw_in = 2'b11;
    for (int i = 1; i <= 3; i++) push(i, 2'b00, 2'b00, 2'b00);
    wait_cyc(3);
    rst_in = 1'b0;
    expect_step(cyc, 2'b00, 2'b11, 2'b11, 2'b00);
    wait_cyc(10);

    // Return both low, then 2: clean rise and fall on channel 0
    expect_step(cyc, 2'b11, 2'b00, 2'b00, 2'b11);
    raw_in = 2'b00;
    wait_cyc(10);
    expect_step(cyc, 2'b00, 2'b01, 2'b01, 2'b00);
    raw_in = 2'b01;
    wait_cyc(10);
    expect_step(cyc, 2'b01, 2'b00, 2'b00, 2'b01);
    raw_in = 2'b00;
    wait_cyc(10);

    // 3: bouncing channel 1, then a 3-sample glitch one short of acceptance
    c0 = cyc;
    for (int i = 1; i <= 21; i++) push(c0 + i, 2'b00, 2'b00, 2'b00);
    raw_in = 2'b10; wait_cyc(2);
    raw_in = 2'b00; wait_cyc(2);
    raw_in = 2'b10; wait_cyc(2);
    raw_in = 2'b00; wait_cyc(6);
    raw_in = 2'b10; wait_cyc(3);
    raw_in = 2'b00; wait_cyc(7);

    // 4: staggered independent rises two cycles apart
    c0 = cyc;
    push(c0 + 5, 2'b00, 2'b00, 2'b00);
    push(c0 + 6, 2'b01, 2'b01, 2'b00);
    push(c0 + 7, 2'b01, 2'b00, 2'b00);
    push(c0 + 8, 2'b11, 2'b10, 2'b00);
    push(c0 + 9, 2'b11, 2'b00, 2'b00);
    raw_in = 2'b01; wait_cyc(2);
    raw_in = 2'b11; wait_cyc(8);
    expect_step(cyc, 2'b11, 2'b00, 2'b00, 2'b11);
    raw_in = 2'b00;
    wait_cyc(10);

    // 5: reset on the 4th edge of a check aborts it; a fresh full debounce follows
    c0 = cyc;
    for (int i = 4; i <= 10; i++) push(c0 + i, 2'b00, 2'b00, 2'b00);
    push(c0 + 11, 2'b01, 2'b01, 2'b00);
    push(c0 + 12, 2'b01, 2'b00, 2'b00);
    raw_in = 2'b01;
    wait_cyc(3);
    rst_in = 1'b1;
    wait_cyc(2);
    rst_in = 1'b0;
    wait_cyc(10);

    // 6: sweep into the half adder
    for (int k = 0; k < 4; k++) begin
      c0 = cyc;
      expect_step(c0, sw_prev[k], sw_raw[k], sw_rise[k], sw_fall[k]);
      push_ha(c0 + 9, sw_raw[k], sw_sum[k], sw_carry[k]);
      raw_in = sw_raw[k];
      wait_cyc(10);
    end

    wait_cyc(3);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expectations: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
